// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the unified memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the fetch/MEM/memory environment.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              stray_rvalid;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata,
    output stray_rvalid
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata,
    input  stray_rvalid
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the load/store path,
// one transaction in flight, data side favoured with a bounded-starvation guarantee for fetch.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    D_WAIT  = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              stray_q, stray_d;

  logic              in_idle;
  logic              d_sel, i_sel;
  logic              if_gnt, d_gnt;
  logic              if_rvalid, d_rvalid;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] if_rdata, d_rdata;

  // Owner selection and memory-side drive; gated by rst_n so reset forces every output low.
  always_comb begin
    in_idle   = rst_n && (state_q == IDLE);
    d_sel     = in_idle && bus.d_req && (!bus.if_req || (starve_q < LIMIT));
    i_sel     = in_idle && bus.if_req && !d_sel;
    mem_req   = d_sel || i_sel;
    mem_we    = d_sel && bus.d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (d_sel) begin
      mem_addr = bus.d_addr;
      if (bus.d_we) begin
        mem_wdata = bus.d_wdata;
        mem_be    = bus.d_be;
      end else begin
        mem_be    = '1;
      end
    end else if (i_sel) begin
      mem_addr = bus.if_addr;
      mem_be   = '1;
    end
    d_gnt     = d_sel && bus.mem_ready;
    if_gnt    = i_sel && bus.mem_ready;
    if_rvalid = rst_n && (state_q == IF_WAIT) && bus.mem_rvalid;
    d_rvalid  = rst_n && (state_q == D_WAIT) && bus.mem_rvalid;
    if_rdata  = if_rvalid ? bus.mem_rdata : '0;
    d_rdata   = d_rvalid  ? bus.mem_rdata : '0;
  end

  // Starvation counter: counts data wins over a waiting fetch, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || if_gnt) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q < LIMIT)) begin
      starve_d = starve_q + CNT_W'(1);
    end
    stray_d = stray_q | ((state_q == IDLE) && bus.mem_rvalid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      stray_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stray_q  <= stray_d;
      case (state_q)
        IDLE: begin
          if (if_gnt) begin
            state_q <= IF_WAIT;
          end else if (d_gnt && !bus.d_we) begin
            state_q <= D_WAIT;
          end
        end
        IF_WAIT: if (bus.mem_rvalid) state_q <= IDLE;
        D_WAIT:  if (bus.mem_rvalid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt       = if_gnt;
  assign bus.if_rvalid    = if_rvalid;
  assign bus.if_rdata     = if_rdata;
  assign bus.d_gnt        = d_gnt;
  assign bus.d_rvalid     = d_rvalid;
  assign bus.d_rdata      = d_rdata;
  assign bus.mem_req      = mem_req;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_wdata    = mem_wdata;
  assign bus.mem_be       = mem_be;
  assign bus.stray_rvalid = stray_q;
endmodule
